// File: rtl/risc_v_io_pkg.sv
// Shared constants for the memory-mapped I/O port: register map, STATUS/CTRL
// bit positions, default window base and the STATUS word packer.
package risc_v_io_pkg;

  localparam logic [31:0] IO_BASE_DEFAULT = 32'hFFFF_FF00;

  typedef enum logic [1:0] {
    REG_DATA   = 2'd0,
    REG_STATUS = 2'd1,
    REG_CTRL   = 2'd2,
    REG_RSVD   = 2'd3
  } io_reg_e;

  localparam int unsigned ST_RX_NE      = 0;
  localparam int unsigned ST_TX_FULL    = 1;
  localparam int unsigned ST_TX_EMPTY   = 2;
  localparam int unsigned ST_TX_DROP    = 3;
  localparam int unsigned ST_RX_CNT_LSB = 8;
  localparam int unsigned ST_TX_CNT_LSB = 16;

  localparam int unsigned CTRL_RX_IE    = 0;
  localparam int unsigned CTRL_TX_IE    = 1;
  localparam int unsigned CTRL_CLR_DROP = 4;

  typedef struct packed {
    logic tx_ie;
    logic rx_ie;
  } io_ctrl_t;

  function automatic logic [31:0] status_word(input logic       rx_ne,
                                              input logic       tx_full,
                                              input logic       tx_empty,
                                              input logic       tx_drop,
                                              input logic [7:0] rx_cnt,
                                              input logic [7:0] tx_cnt);
    logic [31:0] w;
    w                      = '0;
    w[ST_RX_NE]            = rx_ne;
    w[ST_TX_FULL]          = tx_full;
    w[ST_TX_EMPTY]         = tx_empty;
    w[ST_TX_DROP]          = tx_drop;
    w[ST_RX_CNT_LSB +: 8]  = rx_cnt;
    w[ST_TX_CNT_LSB +: 8]  = tx_cnt;
    return w;
  endfunction

endpackage

// File: rtl/io_fifo.sv
// Synchronous FIFO with pre-edge full/empty gating; head reads 0 when empty.
module io_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full & ~rst;
  assign do_pop  = pop & ~empty & ~rst;
  assign rdata   = empty ? '0 : mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/risc_v_io_port.sv
// Memory-mapped I/O unit: N buffered RX/TX channels on the core's data bus,
// with per-channel STATUS/CTRL registers and a combined interrupt.
module risc_v_io_port
  import risc_v_io_pkg::*;
#(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned N_CH       = 2,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter logic [31:0] IO_BASE    = IO_BASE_DEFAULT
) (
  input  logic                     CLK,
  input  logic                     Reset,
  input  logic [31:0]              Addr,
  input  logic                     WE,
  input  logic                     RE,
  input  logic [31:0]              WData,
  output logic                     IOSel,
  output logic [31:0]              RData,
  input  logic [N_CH*DATA_W-1:0]   InData,
  input  logic [N_CH-1:0]          InValid,
  output logic [N_CH-1:0]          InReady,
  output logic [N_CH*DATA_W-1:0]   OutData,
  output logic [N_CH-1:0]          OutValid,
  input  logic [N_CH-1:0]          OutReady,
  output logic                     Irq
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

  io_reg_e           reg_sel;
  logic [3:0]        ch_sel;
  logic              access;
  logic [31:0]       rd_mux;

  logic [DATA_W-1:0] rx_head  [N_CH];
  logic [DATA_W-1:0] tx_head  [N_CH];
  logic [CNT_W-1:0]  rx_count [N_CH];
  logic [CNT_W-1:0]  tx_count [N_CH];
  logic [N_CH-1:0]   rx_full;
  logic [N_CH-1:0]   rx_empty;
  logic [N_CH-1:0]   tx_full;
  logic [N_CH-1:0]   tx_empty;
  logic [N_CH-1:0]   tx_drop;
  logic [N_CH-1:0]   rx_ie;
  logic [N_CH-1:0]   tx_ie;
  logic [N_CH-1:0]   irq_vec;
  logic              unused_bits;

  assign IOSel       = (Addr[31:8] == IO_BASE[31:8]);
  assign access      = IOSel & (RE | WE);
  assign ch_sel      = Addr[7:4];
  assign reg_sel     = io_reg_e'(Addr[3:2]);
  assign Irq         = |irq_vec;
  assign unused_bits = ^{Addr[1:0], WData};

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    logic     hit;
    logic     rx_push;
    logic     rx_pop;
    logic     tx_push;
    logic     tx_pop;
    logic     ctrl_wr;
    logic     drop_q;
    io_ctrl_t ctrl_q;

    assign hit     = access && (ch_sel == 4'(c));
    assign rx_push = InValid[c] & InReady[c];
    assign rx_pop  = hit & RE & (reg_sel == REG_DATA);
    assign tx_push = hit & WE & (reg_sel == REG_DATA);
    assign tx_pop  = OutValid[c] & OutReady[c];
    assign ctrl_wr = hit & WE & (reg_sel == REG_CTRL);

    // InReady is forced low during reset so no external push lands in that cycle.
    assign InReady[c]                   = ~Reset & ~rx_full[c];
    assign OutValid[c]                  = ~tx_empty[c];
    assign OutData[c*DATA_W +: DATA_W]  = tx_head[c];

    assign tx_drop[c] = drop_q;
    assign rx_ie[c]   = ctrl_q.rx_ie;
    assign tx_ie[c]   = ctrl_q.tx_ie;
    assign irq_vec[c] = (ctrl_q.rx_ie & ~rx_empty[c]) | (ctrl_q.tx_ie & tx_empty[c]);

    io_fifo #(.WIDTH(DATA_W), .DEPTH(FIFO_DEPTH)) u_rx (
      .clk   (CLK),
      .rst   (Reset),
      .push  (rx_push),
      .pop   (rx_pop),
      .wdata (InData[c*DATA_W +: DATA_W]),
      .rdata (rx_head[c]),
      .full  (rx_full[c]),
      .empty (rx_empty[c]),
      .count (rx_count[c])
    );

    io_fifo #(.WIDTH(DATA_W), .DEPTH(FIFO_DEPTH)) u_tx (
      .clk   (CLK),
      .rst   (Reset),
      .push  (tx_push),
      .pop   (tx_pop),
      .wdata (WData[DATA_W-1:0]),
      .rdata (tx_head[c]),
      .full  (tx_full[c]),
      .empty (tx_empty[c]),
      .count (tx_count[c])
    );

    // Store to a full TX is judged on pre-edge fullness and flags a sticky drop.
    always_ff @(posedge CLK) begin
      if (Reset) begin
        ctrl_q <= '0;
        drop_q <= 1'b0;
      end else begin
        if (tx_push && tx_full[c]) drop_q <= 1'b1;
        if (ctrl_wr) begin
          ctrl_q.rx_ie <= WData[CTRL_RX_IE];
          ctrl_q.tx_ie <= WData[CTRL_TX_IE];
          if (WData[CTRL_CLR_DROP]) drop_q <= 1'b0;
        end
      end
    end
  end

  // Read mux: unmapped channels and the reserved slot read as zero.
  always_comb begin
    rd_mux = '0;
    for (int c = 0; c < N_CH; c++) begin
      if (ch_sel == 4'(c)) begin
        case (reg_sel)
          REG_DATA:   rd_mux = 32'(rx_head[c]);
          REG_STATUS: rd_mux = status_word(~rx_empty[c], tx_full[c], tx_empty[c],
                                           tx_drop[c], 8'(rx_count[c]), 8'(tx_count[c]));
          REG_CTRL:   rd_mux = {30'd0, tx_ie[c], rx_ie[c]};
          default:    rd_mux = '0;
        endcase
      end
    end
  end

  assign RData = IOSel ? rd_mux : '0;

endmodule

// File: tb/tb_risc_v_io_port.sv
// Randomized bench for risc_v_io_port against a queue-based channel model.
module tb_risc_v_io_port;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned N_CH   = 2;
  localparam int unsigned DEPTH  = 4;
  localparam logic [31:0] BASE   = 32'hFFFF_FF00;

  logic                   CLK = 1'b0;
  logic                   Reset;
  logic [31:0]            Addr;
  logic                   WE;
  logic                   RE;
  logic [31:0]            WData;
  logic                   IOSel;
  logic [31:0]            RData;
  logic [N_CH*DATA_W-1:0] InData;
  logic [N_CH-1:0]        InValid;
  logic [N_CH-1:0]        InReady;
  logic [N_CH*DATA_W-1:0] OutData;
  logic [N_CH-1:0]        OutValid;
  logic [N_CH-1:0]        OutReady;
  logic                   Irq;

  risc_v_io_port #(
    .DATA_W(DATA_W), .N_CH(N_CH), .FIFO_DEPTH(DEPTH), .IO_BASE(BASE)
  ) dut (
    .CLK(CLK), .Reset(Reset), .Addr(Addr), .WE(WE), .RE(RE), .WData(WData),
    .IOSel(IOSel), .RData(RData), .InData(InData), .InValid(InValid),
    .InReady(InReady), .OutData(OutData), .OutValid(OutValid),
    .OutReady(OutReady), .Irq(Irq)
  );

  always #5 CLK = ~CLK;

  int checks   = 0;
  int failures = 0;

  // Reference model: one queue per FIFO plus the control bits.
  logic [DATA_W-1:0] rxq [N_CH][$];
  logic [DATA_W-1:0] txq [N_CH][$];
  bit                m_rx_ie [N_CH];
  bit                m_tx_ie [N_CH];
  bit                m_drop  [N_CH];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] addr(input int ch, input int r);
    return {BASE[31:8], 4'(ch), 2'(r), 2'b00};
  endfunction

  function automatic logic [31:0] model_status(input int c);
    logic [31:0] w;
    int rn;
    int tn;
    rn = rxq[c].size();
    tn = txq[c].size();
    w = 32'(tn) * 32'h1_0000 + 32'(rn) * 32'h100;
    if (rn > 0)            w = w + 32'd1;
    if (tn == int'(DEPTH)) w = w + 32'd2;
    if (tn == 0)           w = w + 32'd4;
    if (m_drop[c])         w = w + 32'd8;
    return w;
  endfunction

  function automatic logic [31:0] model_rdata();
    int c;
    int r;
    c = int'(Addr[7:4]);
    r = int'(Addr[3:2]);
    if (c >= int'(N_CH)) return 32'd0;
    case (r)
      0:       return (rxq[c].size() > 0) ? 32'(rxq[c][0]) : 32'd0;
      1:       return model_status(c);
      2:       return {30'd0, m_tx_ie[c], m_rx_ie[c]};
      default: return 32'd0;
    endcase
  endfunction

  task automatic compare_outputs();
    logic sel;
    logic irq;
    sel = (Addr[31:8] == BASE[31:8]);
    irq = 1'b0;
    check("iosel", 32'(IOSel), 32'(sel));
    if (sel) check("rdata", RData, model_rdata());
    for (int c = 0; c < int'(N_CH); c++) begin
      check($sformatf("inready%0d", c), 32'(InReady[c]),
            32'(!Reset && rxq[c].size() < int'(DEPTH)));
      check($sformatf("outvalid%0d", c), 32'(OutValid[c]), 32'(txq[c].size() > 0));
      check($sformatf("outdata%0d", c), 32'(OutData[c*DATA_W +: DATA_W]),
            (txq[c].size() > 0) ? 32'(txq[c][0]) : 32'd0);
      if ((m_rx_ie[c] && rxq[c].size() > 0) || (m_tx_ie[c] && txq[c].size() == 0)) irq = 1'b1;
    end
    check("irq", 32'(Irq), 32'(irq));
  endtask

  // Advance the model by one rising edge using the pre-edge occupancy.
  task automatic model_update();
    bit acc;
    int r;
    acc = (Addr[31:8] == BASE[31:8]) && (RE || WE);
    r   = int'(Addr[3:2]);
    for (int c = 0; c < int'(N_CH); c++) begin
      if (Reset) begin
        rxq[c].delete();
        txq[c].delete();
        m_rx_ie[c] = 0;
        m_tx_ie[c] = 0;
        m_drop[c]  = 0;
      end else begin
        int  rn;
        int  tn;
        bit  hit;
        bit  push_rx;
        bit  pop_rx;
        bit  push_tx;
        bit  pop_tx;
        rn      = rxq[c].size();
        tn      = txq[c].size();
        hit     = acc && (int'(Addr[7:4]) == c);
        push_rx = InValid[c] && rn < int'(DEPTH);
        pop_tx  = OutReady[c] && tn > 0;
        pop_rx  = hit && r == 0 && RE && rn > 0;
        push_tx = 0;
        if (hit && r == 0 && WE) begin
          if (tn < int'(DEPTH)) push_tx = 1;
          else                  m_drop[c] = 1;
        end
        if (hit && r == 2 && WE) begin
          m_rx_ie[c] = WData[0];
          m_tx_ie[c] = WData[1];
          if (WData[4]) m_drop[c] = 0;
        end
        if (pop_rx)  void'(rxq[c].pop_front());
        if (push_rx) rxq[c].push_back(InData[c*DATA_W +: DATA_W]);
        if (pop_tx)  void'(txq[c].pop_front());
        if (push_tx) txq[c].push_back(WData[DATA_W-1:0]);
      end
    end
  endtask

  task automatic step(input logic rst, input logic [31:0] a, input logic we, input logic re,
                      input logic [31:0] wd, input logic [N_CH*DATA_W-1:0] ind,
                      input logic [N_CH-1:0] iv, input logic [N_CH-1:0] ordy);
    @(negedge CLK);
    Reset = rst; Addr = a; WE = we; RE = re; WData = wd;
    InData = ind; InValid = iv; OutReady = ordy;
    #1;
    compare_outputs();
    @(posedge CLK);
    model_update();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, '0, '0, '0);
  endtask

  initial begin
    Reset = 1'b1; Addr = '0; WE = 1'b0; RE = 1'b0; WData = '0;
    InData = '0; InValid = '0; OutReady = '0;
    repeat (2) @(posedge CLK);
    step(1'b1, 32'h0, 1'b0, 1'b0, 32'h0, '0, 2'b11, 2'b11);

    // Reset state seen through STATUS of channel 0.
    step(1'b0, addr(0, 1), 1'b0, 1'b1, 32'h0, '0, '0, '0);
    #1;
    check("rst_status", RData, 32'h0000_0004);
    check("rst_inready", 32'(InReady), 32'h3);
    check("rst_outvalid", 32'(OutValid), 32'h0);
    check("rst_irq", 32'(Irq), 32'h0);

    // Two external pushes on ch1 then three CPU reads.
    step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, {32'h11, 32'h0}, 2'b10, '0);
    step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, {32'h22, 32'h0}, 2'b10, '0);
    for (int i = 0; i < 3; i++) step(1'b0, addr(1, 0), 1'b0, 1'b1, 32'h0, '0, '0, '0);
    step(1'b0, addr(1, 1), 1'b0, 1'b1, 32'h0, '0, '0, '0);
    #1;
    check("rx_drained_status", RData, 32'h0000_0004);

    // Overfill TX ch0 with the sink stalled, then clear the drop flag.
    for (int i = 0; i < 5; i++) step(1'b0, addr(0, 0), 1'b1, 1'b0, 32'hA0 + 32'(i), '0, '0, '0);
    step(1'b0, addr(0, 1), 1'b0, 1'b1, 32'h0, '0, '0, '0);
    #1;
    check("tx_full_status", RData, 32'h0004_000A);
    check("tx_full_outdata", OutData[31:0], 32'hA0);
    step(1'b0, addr(0, 2), 1'b1, 1'b0, 32'h10, '0, '0, '0);
    step(1'b0, addr(0, 1), 1'b0, 1'b1, 32'h0, '0, '0, '0);
    #1;
    check("drop_cleared_status", RData, 32'h0004_0002);
    for (int i = 0; i < 5; i++) step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, '0, '0, 2'b01);

    // Fill RX ch0, then pop with InValid held: push waits one edge.
    for (int i = 0; i < 4; i++) step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, {32'h0, 32'h50 + 32'(i)}, 2'b01, '0);
    step(1'b0, addr(0, 0), 1'b0, 1'b1, 32'h0, {32'h0, 32'h99}, 2'b01, '0);
    #1;
    check("rx_after_pop_inready", 32'(InReady[0]), 32'h1);
    step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, {32'h0, 32'h99}, 2'b01, '0);
    for (int i = 0; i < 4; i++) step(1'b0, addr(0, 0), 1'b0, 1'b1, 32'h0, '0, '0, '0);

    // RX interrupt on ch1.
    step(1'b0, addr(1, 2), 1'b1, 1'b0, 32'h1, '0, '0, '0);
    step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, {32'h77, 32'h0}, 2'b10, '0);
    #1;
    check("irq_set", 32'(Irq), 32'h1);
    step(1'b0, addr(1, 0), 1'b0, 1'b1, 32'h0, '0, '0, '0);
    #1;
    check("irq_clear", 32'(Irq), 32'h0);
    step(1'b0, addr(1, 2), 1'b1, 1'b0, 32'h0, '0, '0, '0);

    // Reset in the middle of a TX drain.
    for (int i = 0; i < 3; i++) step(1'b0, addr(0, 0), 1'b1, 1'b0, 32'hC0 + 32'(i), '0, '0, '0);
    step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, '0, '0, 2'b01);
    step(1'b1, 32'h0, 1'b0, 1'b0, 32'h0, '0, 2'b11, 2'b11);
    #1;
    check("mid_reset_outvalid", 32'(OutValid), 32'h0);
    step(1'b0, addr(0, 1), 1'b0, 1'b1, 32'h0, '0, '0, '0);
    #1;
    check("mid_reset_status", RData, 32'h0000_0004);

    // Randomized traffic with per-block pressure on both sides.
    for (int blk = 0; blk < 15; blk++) begin
      int ordy_pct;
      int iv_pct;
      ordy_pct = int'($urandom_range(0, 100));
      iv_pct   = int'($urandom_range(0, 100));
      for (int i = 0; i < 200; i++) begin
        logic [31:0]            a;
        logic [N_CH-1:0]        iv;
        logic [N_CH-1:0]        ordy;
        for (int c = 0; c < int'(N_CH); c++) begin
          iv[c]   = (int'($urandom_range(0, 99)) < iv_pct);
          ordy[c] = (int'($urandom_range(0, 99)) < ordy_pct);
        end
        if ($urandom_range(0, 9) == 0) a = $urandom;
        else a = addr(int'($urandom_range(0, 3)), int'($urandom_range(0, 3))) | 32'($urandom_range(0, 3));
        step(($urandom_range(0, 99) == 0), a, ($urandom_range(0, 99) < 35),
             ($urandom_range(0, 99) < 35), $urandom, {$urandom, $urandom}, iv, ordy);
      end
    end
    idle(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/risc_v_io_port.md
# risc_v_io_port

Parametrised, memory-mapped I/O unit replacing the single 32-bit CPUIn/CPUOut pair of the single-cycle RISC-V core with N independent buffered channels. It sits on the core's data-memory bus (ALUResult as address, store/load strobes) beside data memory. Each channel has an RX FIFO fed by an external valid/ready source and a TX FIFO drained by an external valid/ready sink, plus status and interrupt-enable registers.

## Interface
- DATA_W, 32, channel data width (≤ 32; zero-extended onto RData)
- N_CH, 2, number of channels (1..16)
- FIFO_DEPTH, 4, entries per FIFO, power of two, ≥ 2
- IO_BASE, 32'hFFFF_FF00, base of 256-byte I/O window
- CLK  in  1  clock, rising edge
- Reset  in  1  synchronous, active-high
- Addr  in  32  CPU byte address (ALUResult)
- WE  in  1  CPU store strobe
- RE  in  1  CPU load strobe
- WData  in  32  CPU store data
- IOSel  out  1  combinational: Addr[31:8] == IO_BASE[31:8]; selects RData over data memory
- RData  out  32  combinational read data
- InData  in  N_CH*DATA_W  external RX data, channel c at [c*DATA_W +: DATA_W]
- InValid  in  N_CH  external RX valid
- InReady  out  N_CH  RX FIFO not full
- OutData  out  N_CH*DATA_W  TX FIFO head
- OutValid  out  N_CH  TX FIFO not empty
- OutReady  in  N_CH  external TX ready
- Irq  out  1  OR over channels of (RX_IE & RX not empty) | (TX_IE & TX empty)

## Operation
- Channel c window at IO_BASE + 16*c; Addr[7:4]=c, Addr[3:2]=register; channels ≥ N_CH read 0, writes ignored.
- +0 DATA: read returns RX head (0 if empty); RE pops RX if non-empty. Write pushes WData[DATA_W-1:0] to TX if not full, else dropped and TX_DROP sticky set.
- +4 STATUS (read-only): bit0 RX non-empty, bit1 TX full, bit2 TX empty, bit3 TX_DROP, bits[15:8] RX count, bits[23:16] TX count.
- +8 CTRL: bit0 RX_IE, bit1 TX_IE (R/W); write with bit4=1 clears TX_DROP (self-clearing, reads 0).
- +12: reads 0, writes ignored.
- Access takes effect only when IOSel & (RE|WE); RE and WE together: write effect and read pop both apply.
- External RX push on InValid & InReady; TX pop on OutValid & OutReady.
- Reset values: all FIFOs empty, counts 0, CTRL 0, TX_DROP 0; InReady = 0 while Reset high, 1 after; OutValid 0, OutData 0, Irq 0.

## Timing
- All state updates on rising CLK; RData, IOSel, OutData, InReady, OutValid combinational from registered state.
- Latency: external push at edge k readable by CPU in cycle k+1; CPU store at edge k gives OutValid=1 in cycle k+1.
- Full/empty decisions use pre-edge state: full RX keeps InReady=0 even if CPU pops same cycle; store to full TX dropped even if sink pops same cycle.
- Simultaneous push and pop on a non-full, non-empty FIFO: both occur, count unchanged.
- Pointers wrap modulo FIFO_DEPTH; count width $clog2(FIFO_DEPTH)+1, saturates at FIFO_DEPTH by construction.
- Reset mid-transfer: contents discarded next edge, no handshake completes in the reset cycle.

## Structure
- Package risc_v_io_pkg: register offsets, STATUS/CTRL bit positions, default IO_BASE.
- Sub-module io_fifo (WIDTH, DEPTH): sync FIFO with push/pop, full/empty, count, head data; instantiated 2×N_CH via generate.
- Top: address decode, register file, read mux, Irq reduction.

## Test plan
- Reset, then read STATUS ch0 -> 32'h0000_0004 (TX empty only); InReady=all 1, OutValid=0, Irq=0.
- External pushes 8'h11, 8'h22 on ch1; CPU reads IO_BASE+16 twice -> 32'h11 then 32'h22; third read -> 0, no pop, STATUS bit0=0.
- CPU stores 5 words to ch0 DATA with OutReady=0, DEPTH=4 -> OutValid=1, TX count 4, fifth dropped, STATUS bit3=1; write CTRL 32'h10 -> bit3=0.
- RX fill ch0 to 4 -> InReady[0]=0; CPU pop with InValid held same cycle -> no push that edge, InReady[0]=1 next cycle, push completes following edge.
- Write CTRL ch1 = 1, push one RX word -> Irq=1 in next cycle; pop it -> Irq=0.
- Load TX with 3 words, assert Reset for one cycle mid-drain -> OutValid=0 next cycle, TX count 0.
